// File: rtl/step_rate_gen_if.sv
// Control/status bundle between the step-rate generator and the motor controller.
// The controller drives the master side; step_rate_gen sits on the slave side.
interface step_rate_gen_if;
  logic               enable;
  logic               direction;
  logic [1:0]         motorSpeed;
  logic               step_tick;
  logic               step_dir;
  logic               running;
  logic               at_speed;
  logic signed [15:0] step_pos;

  modport master (
    output enable, direction, motorSpeed,
    input  step_tick, step_dir, running, at_speed, step_pos
  );

  modport slave (
    input  enable, direction, motorSpeed,
    output step_tick, step_dir, running, at_speed, step_pos
  );
endinterface

// File: rtl/step_rate_gen.sv
// Ramped step-pulse generator feeding the motor-phase FSM; direction only changes at standstill rate.
// Optional signed step position counter is built when STEP_COUNT_EN is defined.
module step_rate_gen #(
  parameter int unsigned PERIOD_W  = 32,
  parameter int unsigned PER_START = 2000000,
  parameter int unsigned PER_S0    = 2000000,
  parameter int unsigned PER_S1    = 1000000,
  parameter int unsigned PER_S2    = 500000,
  parameter int unsigned PER_S3    = 250000,
  parameter int unsigned RAMP_DEC  = 50000
) (
  input  logic           clock,
  input  logic           reset,
  step_rate_gen_if.slave bus
);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(PER_START);
  localparam logic [PERIOD_W-1:0] RAMP_P  = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W-1:0] ONE_P   = PERIOD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_STOPPING
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic                step_dir_q, step_dir_d;

  logic [PERIOD_W-1:0] target;
  logic [PERIOD_W-1:0] ramp_tgt;
  logic [PERIOD_W-1:0] ramp_stop;
  logic                tick;
  logic                keep_running;

  function automatic state_t cmp_state(input logic [PERIOD_W-1:0] p,
                                       input logic [PERIOD_W-1:0] t);
    if (p > t)      return S_ACCEL;
    else if (p < t) return S_DECEL;
    else            return S_CRUISE;
  endfunction

  always_comb begin
    target = PERIOD_W'(PER_S0);
    unique case (bus.motorSpeed)
      2'd0: target = PERIOD_W'(PER_S0);
      2'd1: target = PERIOD_W'(PER_S1);
      2'd2: target = PERIOD_W'(PER_S2);
      2'd3: target = PERIOD_W'(PER_S3);
      default: target = PERIOD_W'(PER_S0);
    endcase
  end

  // Step toward the goal by at most RAMP_DEC; comparing the gap first keeps
  // the arithmetic free of underflow/overflow.
  always_comb begin
    ramp_tgt = target;
    if (cur_period_q > target) begin
      if ((cur_period_q - target) > RAMP_P) ramp_tgt = cur_period_q - RAMP_P;
    end else if (cur_period_q < target) begin
      if ((target - cur_period_q) > RAMP_P) ramp_tgt = cur_period_q + RAMP_P;
    end

    ramp_stop = START_P;
    if (cur_period_q < START_P && (START_P - cur_period_q) > RAMP_P)
      ramp_stop = cur_period_q + RAMP_P;
  end

  assign tick         = (state_q != S_IDLE) && (cnt_q == cur_period_q - ONE_P);
  assign keep_running = bus.enable && (bus.direction == step_dir_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_period_d = cur_period_q;
    step_dir_d   = step_dir_q;

    if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + ONE_P;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.enable) begin
          state_d    = S_ACCEL;
          step_dir_d = bus.direction;
        end
      end

      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (tick) cur_period_d = ramp_tgt;
        // Classify on the post-update period so CRUISE lands on the loading edge.
        if (!keep_running) state_d = S_STOPPING;
        else               state_d = cmp_state(cur_period_d, target);
      end

      S_STOPPING: begin
        if (tick) cur_period_d = ramp_stop;
        if (cur_period_q == START_P) begin
          if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d    = S_ACCEL;
            step_dir_d = bus.direction;
          end
        end else if (keep_running) begin
          state_d = cmp_state(cur_period_d, target);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_period_q <= START_P;
      step_dir_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_period_q <= cur_period_d;
      step_dir_q   <= step_dir_d;
    end
  end

  assign bus.step_tick = tick;
  assign bus.step_dir  = step_dir_q;
  assign bus.running   = (state_q != S_IDLE);
  assign bus.at_speed  = (state_q == S_CRUISE) && (cur_period_q == target);

`ifdef STEP_COUNT_EN
  logic signed [15:0] step_pos_q, step_pos_d;

  always_comb begin
    step_pos_d = step_pos_q;
    if (tick) step_pos_d = step_dir_q ? step_pos_q + 16'sd1 : step_pos_q - 16'sd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) step_pos_q <= '0;
    else        step_pos_q <= step_pos_d;
  end

  assign bus.step_pos = step_pos_q;
`else
  assign bus.step_pos = '0;
`endif

endmodule

// File: tb/tb_step_rate_gen.sv
// Scoreboard bench for step_rate_gen: stimulus queues expected tick intervals,
// a monitor pops and compares them on every step_tick.
module tb_step_rate_gen;

  logic clock;
  logic reset;

  step_rate_gen_if bus ();

  step_rate_gen #(
    .PERIOD_W (32),
    .PER_START(20),
    .PER_S0   (20),
    .PER_S1   (16),
    .PER_S2   (12),
    .PER_S3   (8),
    .RAMP_DEC (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int   iv;
    logic dir;
    logic at;
    int   pos;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_pos = 0;
  int   since = 0;

`ifdef STEP_COUNT_EN
  localparam int POS_AFTER_T6 = 2;
`else
  localparam int POS_AFTER_T6 = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int iv, input logic dir, input logic at);
    exp_t e;
    e.iv  = iv;
    e.dir = dir;
    e.at  = at;
    e.pos = exp_pos;
`ifdef STEP_COUNT_EN
    exp_pos = dir ? exp_pos + 1 : exp_pos - 1;
`endif
    exp_q.push_back(e);
  endtask

  // Returns in the cycle right after the last expected tick edge (cnt == 0).
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!bus.running) since = 0;
      else              since++;
      if (bus.step_tick) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tick_interval", since, e.iv);
          check("tick_dir", int'(bus.step_dir), int'(e.dir));
          check("tick_at_speed", int'(bus.at_speed), int'(e.at));
          check("tick_step_pos", int'(bus.step_pos), e.pos);
        end
        since = 0;
      end
    end
  end

  // Stimulus
  initial begin
    reset          = 1'b0;
    bus.enable     = 1'b0;
    bus.direction  = 1'b0;
    bus.motorSpeed = 2'd0;
    repeat (3) @(negedge clock);
    check("rst_running", int'(bus.running), 0);
    check("rst_tick", int'(bus.step_tick), 0);
    check("rst_dir", int'(bus.step_dir), 0);
    check("rst_at_speed", int'(bus.at_speed), 0);
    check("rst_pos", int'(bus.step_pos), 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_running", int'(bus.running), 0);

    // Start at speed 0, forward: steady 20-clock intervals
    bus.direction = 1'b1;
    bus.enable    = 1'b1;
    @(posedge clock); #1;
    check("t1_running", int'(bus.running), 1);
    for (int i = 0; i < 5; i++) push(20, 1'b1, 1'b1);
    wait_drain(200);
    check("t1_at_speed", int'(bus.at_speed), 1);

    // Reverse at standstill rate: three ticks backward
    bus.direction = 1'b0;
    for (int i = 0; i < 3; i++) push(20, 1'b0, 1'b1);
    wait_drain(200);
    check("t6_step_pos", int'(bus.step_pos), POS_AFTER_T6);

    bus.enable = 1'b0;
    repeat (5) @(negedge clock);
    check("stop0_running", int'(bus.running), 0);

    // Start at speed 3: ramp 20,16,12,8
    bus.direction  = 1'b1;
    bus.motorSpeed = 2'd3;
    bus.enable     = 1'b1;
    push(20, 1'b1, 1'b0);
    push(16, 1'b1, 1'b0);
    push(12, 1'b1, 1'b0);
    push(8,  1'b1, 1'b1);
    push(8,  1'b1, 1'b1);
    wait_drain(300);
    check("t2_at_speed", int'(bus.at_speed), 1);

    // Slow down to speed 1
    bus.motorSpeed = 2'd1;
    #1;
    check("t3_at_speed_drop", int'(bus.at_speed), 0);
    push(8,  1'b1, 1'b0);
    push(12, 1'b1, 1'b0);
    push(16, 1'b1, 1'b1);
    push(16, 1'b1, 1'b1);
    wait_drain(300);
    check("t3_at_speed_back", int'(bus.at_speed), 1);

    bus.motorSpeed = 2'd3;
    push(16, 1'b1, 1'b0);
    push(12, 1'b1, 1'b0);
    push(8,  1'b1, 1'b1);
    wait_drain(300);

    // Reverse while fast: ramp down, flip, ramp up
    bus.direction = 1'b0;
    push(8,  1'b1, 1'b0);
    push(12, 1'b1, 1'b0);
    push(16, 1'b1, 1'b0);
    push(20, 1'b0, 1'b0);
    push(16, 1'b0, 1'b0);
    push(12, 1'b0, 1'b0);
    push(8,  1'b0, 1'b1);
    wait_drain(400);
    check("t4_dir", int'(bus.step_dir), 0);

    // Disable while fast: 8,12,16 then idle
    bus.enable = 1'b0;
    push(8,  1'b0, 1'b0);
    push(12, 1'b0, 1'b0);
    push(16, 1'b0, 1'b0);
    wait_drain(300);
    repeat (3) @(negedge clock);
    check("t5_running", int'(bus.running), 0);
    repeat (40) @(negedge clock);
    check("t5_idle_running", int'(bus.running), 0);
    check("t5_idle_tick", int'(bus.step_tick), 0);
    check("t5_idle_dir", int'(bus.step_dir), 0);

    // Asynchronous reset mid-run
    bus.direction  = 1'b1;
    bus.motorSpeed = 2'd2;
    bus.enable     = 1'b1;
    repeat (10) @(negedge clock);
    check("t5r_running_pre", int'(bus.running), 1);
    check("t5r_dir_pre", int'(bus.step_dir), 1);
    #2;
    reset   = 1'b0;
    exp_pos = 0;
    #1;
    check("t5r_running", int'(bus.running), 0);
    check("t5r_tick", int'(bus.step_tick), 0);
    check("t5r_dir", int'(bus.step_dir), 0);
    check("t5r_at_speed", int'(bus.at_speed), 0);
    check("t5r_pos", int'(bus.step_pos), 0);
    bus.enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("t5r_post_running", int'(bus.running), 0);
    check("t5r_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_rate_gen.md
Name: step_rate_gen

Overview:
- Step-timing stage directly upstream of the motor-phase FSM (fsmLogic); replaces the fixed clock divider.
- Converts the 2-bit motorSpeed selection plus enable/direction into single-cycle step_tick pulses and a safe, latched step_dir.
- Applies a linear period ramp on start, stop, speed change and reversal, so the motor never jumps speed or reverses while running fast.
- Sits on the system clock; step_tick acts as the FSM's advance enable.

Parameters:
PERIOD_W, 32, width of period/counter registers
PER_START, 2000000, step period in clocks at start/stop (slowest rate)
PER_S0, 2000000, target period for motorSpeed=0
PER_S1, 1000000, target period for motorSpeed=1
PER_S2, 500000, target period for motorSpeed=2
PER_S3, 250000, target period for motorSpeed=3
RAMP_DEC, 50000, period change applied per step while ramping
(Constraints: all PER_Sx <= PER_START; RAMP_DEC >= 1.)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = run motor, 0 = ramp down and stop
direction  in  1  requested rotation direction
motorSpeed  in  2  target speed select (0 slowest .. 3 fastest)
step_tick  out  1  one-clock pulse per motor step
step_dir  out  1  direction the FSM must apply; changes only at standstill speed
running  out  1  1 in any state except IDLE
at_speed  out  1  1 when cur_period equals the selected target and state is CRUISE
step_pos  out  16  signed step position (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, cur_period=PER_START. All outputs 0.
- target = PER_Sx selected combinationally by motorSpeed.
- Tick generation: outside IDLE, cnt increments each clock. When cnt==cur_period-1: step_tick=1 and cnt<=0.
- Any ramp update of cur_period is registered on the tick edge and governs the next interval.
- ACCEL/CRUISE/DECEL ramp: on each tick, cur_period moves toward target by RAMP_DEC, saturating at target.
- STOPPING ramp: on each tick, cur_period moves toward PER_START, saturating at PER_START.
- States:
  - IDLE: no ticks, cnt held at 0. enable=1 -> ACCEL; step_dir<=direction in the same edge.
  - ACCEL (cur_period>target) / DECEL (cur_period<target) / CRUISE (cur_period==target):
    - State is re-evaluated every cycle from the cur_period vs target comparison.
    - A motorSpeed change mid-ramp redirects the ramp immediately; no restart.
  - Entry to STOPPING from ACCEL/CRUISE/DECEL occurs on any cycle where enable=0 or direction!=step_dir.
  - STOPPING, checked every cycle while cur_period==PER_START:
    - enable=0 -> IDLE; cnt<=0.
    - Otherwise step_dir<=direction and -> ACCEL; cnt continues.
  - STOPPING with enable=1 and direction==step_dir before reaching PER_START -> resume ACCEL/CRUISE/DECEL by comparison.
- Outputs:
  - at_speed=1 only in CRUISE; it drops the same cycle target changes.
  - step_dir never changes while cur_period<PER_START.
- Boundaries:
  - Ramp arithmetic saturates; there is no underflow or overflow.
  - Simultaneous enable drop and direction flip are handled as a plain stop.
  - Reset mid-run aborts immediately; there is no ramp-down.

Optional Feature:
- Macro STEP_COUNT_EN.
- Defined: step_pos updates on each step_tick, +1 if step_dir=1 and -1 if step_dir=0. It is 16-bit two's complement, wraps at +/-32768, and clears on reset.
- Undefined: step_pos is tied to 0 and no counter logic is built.

Test Plan:
All scenarios use PER_START=20, PER_S0=20, S1=16, S2=12, S3=8, RAMP_DEC=4.
1. Reset, then enable=1, motorSpeed=0 -> running=1 next cycle; first step_tick 20 cycles after enable is sampled; intervals 20,20,...; at_speed=1.
2. Start with motorSpeed=3 -> tick intervals 20,16,12,8,8...; at_speed rises on the edge that loads 8.
3. Cruising at speed 3, switch to motorSpeed=1 -> at_speed drops immediately; intervals 8,12,16,16...; at_speed reasserts when the period reaches 16.
4. Cruising at speed 3, flip direction:
   - Intervals 8,12,16 with the old step_dir; step_dir toggles when the period reaches 20.
   - Then intervals 20,16,12,8 follow with the new direction.
5. Disable at speed 3 -> intervals 8,12,16, then IDLE with no further ticks and running=0. Separately, assert reset mid-run -> all outputs 0 asynchronously.
6. With STEP_COUNT_EN defined: 5 forward ticks, reverse, 3 ticks -> step_pos=2. Without the macro -> step_pos stays 0.
